// File: rtl/vec_collect_pkg.sv
// Shared helpers for the serial-to-parallel frame collector.
// Frame geometry is derived from the N parameter at each use site.
// No types are exported; out_vec stays a plain packed 2-D array.
package vec_collect_pkg;

  // Number of samples in one frame for a given index width.
  function automatic int frame_len(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/vec_collect_if.sv
// Handshake bundle between a sample producer / frame consumer and vec_collect.
// master drives samples, clr and out_rdy; slave (the collector) answers.
// Parameters must match the collector instance it is bound to.
interface vec_collect_if #(
  parameter int W = 8,
  parameter int N = 4
);
  import vec_collect_pkg::*;

  localparam int L = frame_len(N);

  logic                clr;
  logic [W-1:0]        in_dat;
  logic                in_val;
  logic                in_rdy;
  logic [L-1:0][W-1:0] out_vec;
  logic                out_val;
  logic                out_rdy;
  logic [N:0]          lvl;

  modport slave (
    input  clr, in_dat, in_val, out_rdy,
    output in_rdy, out_vec, out_val, lvl
  );

  modport master (
    output clr, in_dat, in_val, out_rdy,
    input  in_rdy, out_vec, out_val, lvl
  );

endinterface

// File: rtl/vec_collect.sv
// Collects 2**N serial W-bit samples into one packed frame (sample k at index k).
// Latency: frame valid exactly 1 cycle after its last sample is accepted.
// Backpressure: in_rdy drops only when the last sample would overwrite a stalled frame, or on clr.
module vec_collect
  import vec_collect_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  vec_collect_if.slave bus
);

  localparam int L = frame_len(N);
  localparam logic [N-1:0] LAST = '1;

  logic [L-1:0][W-1:0] coll;
  logic [N-1:0]        idx;
  logic                accept;
  logic                frame_done;
  logic                handover;

  // The final sample goes straight into the output register, so collection of
  // the next frame can run up to L-1 samples ahead of a stalled consumer.
  assign bus.in_rdy  = !bus.clr && !((idx == LAST) && bus.out_val && !bus.out_rdy);
  assign accept      = bus.in_val && bus.in_rdy;
  assign frame_done  = accept && (idx == LAST);
  assign handover    = bus.out_val && bus.out_rdy;
  assign bus.lvl     = {1'b0, idx};

  // Write pointer and collection entries; clr only rewinds the pointer, since
  // every entry is rewritten before it can be part of a later frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      coll <= '0;
    end else if (bus.clr) begin
      idx <= '0;
    end else if (accept) begin
      coll[idx] <= bus.in_dat;
      idx       <= idx + 1'b1;
    end
  end

  // Output frame register: a completing frame always reloads, even on the
  // same edge the previous frame is handed over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_vec <= '0;
      bus.out_val <= 1'b0;
    end else if (frame_done) begin
      for (int k = 0; k < L - 1; k++) begin
        bus.out_vec[k] <= coll[k];
      end
      bus.out_vec[L-1] <= bus.in_dat;
      bus.out_val      <= 1'b1;
    end else if (handover) begin
      bus.out_val <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vec_collect.sv
// Self-checking bench for vec_collect: directed scenarios plus random traffic.
// Reference model holds the partial frame as a queue of samples.
// Outputs are checked every cycle, 1-2 time units after the rising edge.
module tb_vec_collect;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int L  = 1 << N;
  localparam int VW = W * L;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  vec_collect_if #(.W(W), .N(N)) bus ();

  vec_collect #(.W(W), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  int                  q[$];
  logic [L-1:0][W-1:0] exp_vec;
  bit                  exp_val;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_rdy();
    return !bus.clr && !((q.size() == L - 1) && exp_val && !bus.out_rdy);
  endfunction

  task automatic model_clear();
    q.delete();
    exp_val = 1'b0;
    exp_vec = '0;
  endtask

  task automatic check_all();
    chk("in_rdy",  VW'(bus.in_rdy),  VW'(model_rdy()));
    chk("out_val", VW'(bus.out_val), VW'(exp_val));
    chk("lvl",     VW'(bus.lvl),     VW'(q.size()));
    chk("out_vec", bus.out_vec,      exp_vec);
  endtask

  // Apply one cycle of inputs, check, advance the model across the edge.
  task automatic cyc(input bit v, input logic [W-1:0] d, input bit ordy, input bit c);
    bit acc;
    bit done;
    bus.in_val  = v;
    bus.in_dat  = d;
    bus.out_rdy = ordy;
    bus.clr     = c;
    #1;
    check_all();
    acc  = v && model_rdy();
    done = 1'b0;
    if (c) begin
      q.delete();
    end else if (acc) begin
      q.push_back(int'(d));
      if (q.size() == L) begin
        for (int k = 0; k < L; k++) exp_vec[k] = W'(q[k]);
        q.delete();
        done = 1'b1;
      end
    end
    if (done) exp_val = 1'b1;
    else if (exp_val && ordy) exp_val = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges and confirm the effect is immediate.
  task automatic async_reset();
    bus.in_val = 1'b0;
    bus.clr    = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("rst_out_val", VW'(bus.out_val), '0);
    chk("rst_lvl",     VW'(bus.lvl),     '0);
    chk("rst_out_vec", bus.out_vec,      '0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rdy_after_rst", VW'(bus.in_rdy), VW'(1));
  endtask

  function automatic int frame_sum();
    int s = 0;
    for (int k = 0; k < L; k++) s += int'(bus.out_vec[k]);
    return s;
  endfunction

  initial begin
    logic [W-1:0] d;
    logic [W-1:0] first;

    rst         = 1'b1;
    bus.in_val  = 1'b0;
    bus.in_dat  = '0;
    bus.out_rdy = 1'b0;
    bus.clr     = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_val", VW'(bus.out_val), '0);
    chk("reset_lvl",     VW'(bus.lvl),     '0);
    chk("reset_out_vec", bus.out_vec,      '0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    #1;
    chk("rdy_first_cycle", VW'(bus.in_rdy), VW'(1));
    #1;
    @(posedge clk);
    #1;

    // Frame of 1..16, consumer ready
    for (int i = 1; i <= L; i++) cyc(1'b1, W'(i), 1'b1, 1'b0);
    #1;
    chk("seq_out_val", VW'(bus.out_val), VW'(1));
    chk("seq_first",   VW'(bus.out_vec[0]), VW'(1));
    chk("seq_last",    VW'(bus.out_vec[L-1]), VW'(16));
    chk("seq_sum",     VW'(frame_sum()), VW'(136));

    // 40 continuous samples: two frames, 8 left over
    for (int i = 0; i < 40; i++) cyc(1'b1, W'($urandom), 1'b1, 1'b0);
    chk("stream_lvl", VW'(bus.lvl), VW'(8));
    for (int i = 0; i < 8; i++) cyc(1'b1, W'($urandom), 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // Stall: frame 1 held, frame 2 collects up to 15 samples then waits
    for (int i = 0; i < L; i++) cyc(1'b1, W'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < L - 1; i++) cyc(1'b1, W'($urandom), 1'b0, 1'b0);
    chk("stall_lvl", VW'(bus.lvl), VW'(15));
    cyc(1'b1, 8'h5A, 1'b0, 1'b0);
    chk("stall_lvl_held", VW'(bus.lvl), VW'(15));
    d = W'($urandom);
    cyc(1'b1, d, 1'b1, 1'b0);
    chk("reload_val",  VW'(bus.out_val), VW'(1));
    chk("reload_last", VW'(bus.out_vec[L-1]), VW'(d));
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("drained", VW'(bus.out_val), '0);

    // clr mid-frame drops the partial frame and the presented sample
    for (int i = 0; i < 5; i++) cyc(1'b1, W'($urandom), 1'b1, 1'b0);
    cyc(1'b1, 8'hAA, 1'b1, 1'b1);
    chk("clr_lvl", VW'(bus.lvl), '0);
    for (int i = 0; i < L; i++) cyc(1'b1, W'(8'h30 + i), 1'b1, 1'b0);
    for (int k = 0; k < L; k++) chk("clean_frame", VW'(bus.out_vec[k]), VW'(8'h30 + k));
    cyc(1'b0, '0, 1'b1, 1'b0);

    // Async reset mid-frame
    for (int i = 0; i < 9; i++) cyc(1'b1, W'($urandom), 1'b1, 1'b0);
    chk("pre_rst_lvl", VW'(bus.lvl), VW'(9));
    async_reset();

    // Async reset during a stalled frame
    for (int i = 0; i < L + 3; i++) cyc(1'b1, W'($urandom), 1'b0, 1'b0);
    chk("pre_rst_stall", VW'(bus.out_val), VW'(1));
    async_reset();
    first = W'($urandom);
    cyc(1'b1, first, 1'b1, 1'b0);
    for (int i = 1; i < L; i++) cyc(1'b1, W'($urandom), 1'b1, 1'b0);
    chk("post_rst_idx0", VW'(bus.out_vec[0]), VW'(first));

    // Random traffic with occasional clr
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 2) != 0,
          $urandom_range(0, 40) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
